// File: rtl/ddr_burst_arbiter.sv
// Arbitrates three burst requesters (isa_rd, data_rd, data_wr) onto one DDR read/write burst port.
// Latency: grant on the edge that samples a request, burst request one cycle later, done one cycle after finish.
// Backpressure: requesters hold req/addr/len until their done pulse; DDR_ARB_ROUND_ROBIN_EN selects round-robin, else fixed priority.
module ddr_burst_arbiter #(
    parameter int DDR_ADDR_WIDTH  = 28,
    parameter int BURST_LEN_WIDTH = 10
) (
    input  logic                       mem_clk,
    input  logic                       rst_n,
    input  logic                       init_calib_complete,
    input  logic                       isa_rd_req,
    input  logic                       data_rd_req,
    input  logic                       data_wr_req,
    input  logic [DDR_ADDR_WIDTH-1:0]  isa_rd_addr,
    input  logic [DDR_ADDR_WIDTH-1:0]  data_rd_addr,
    input  logic [DDR_ADDR_WIDTH-1:0]  data_wr_addr,
    input  logic [BURST_LEN_WIDTH-1:0] isa_rd_len,
    input  logic [BURST_LEN_WIDTH-1:0] data_rd_len,
    input  logic [BURST_LEN_WIDTH-1:0] data_wr_len,
    output logic                       isa_rd_done,
    output logic                       data_rd_done,
    output logic                       data_wr_done,
    output logic                       rd_burst_req,
    output logic                       wr_burst_req,
    output logic [DDR_ADDR_WIDTH-1:0]  rd_burst_addr,
    output logic [DDR_ADDR_WIDTH-1:0]  wr_burst_addr,
    output logic [BURST_LEN_WIDTH-1:0] rd_burst_len,
    output logic [BURST_LEN_WIDTH-1:0] wr_burst_len,
    input  logic                       rd_burst_finish,
    input  logic                       wr_burst_finish,
    output logic                       busy,
    output logic [1:0]                 grant_id
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

    localparam logic [1:0] ID_NONE  = 2'd0;
    localparam logic [1:0] ID_ISA   = 2'd1;
    localparam logic [1:0] ID_DRD   = 2'd2;
    localparam logic [1:0] ID_DWR   = 2'd3;

    state_t                     state;
    logic [1:0]                 sel_id;
    logic [DDR_ADDR_WIDTH-1:0]  sel_addr;
    logic [BURST_LEN_WIDTH-1:0] sel_len;

`ifdef DDR_ARB_ROUND_ROBIN_EN
    // Index of the requester searched first: 0 isa_rd, 1 data_rd, 2 data_wr.
    logic [1:0] rr_ptr;

    always_comb begin
        sel_id = ID_NONE;
        case (rr_ptr)
            2'd1: begin
                if      (data_rd_req) sel_id = ID_DRD;
                else if (data_wr_req) sel_id = ID_DWR;
                else if (isa_rd_req)  sel_id = ID_ISA;
            end
            2'd2: begin
                if      (data_wr_req) sel_id = ID_DWR;
                else if (isa_rd_req)  sel_id = ID_ISA;
                else if (data_rd_req) sel_id = ID_DRD;
            end
            default: begin
                if      (isa_rd_req)  sel_id = ID_ISA;
                else if (data_rd_req) sel_id = ID_DRD;
                else if (data_wr_req) sel_id = ID_DWR;
            end
        endcase
    end
`else
    always_comb begin
        sel_id = ID_NONE;
        if      (data_wr_req) sel_id = ID_DWR;
        else if (data_rd_req) sel_id = ID_DRD;
        else if (isa_rd_req)  sel_id = ID_ISA;
    end
`endif

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        case (sel_id)
            ID_ISA: begin sel_addr = isa_rd_addr;  sel_len = isa_rd_len;  end
            ID_DRD: begin sel_addr = data_rd_addr; sel_len = data_rd_len; end
            ID_DWR: begin sel_addr = data_wr_addr; sel_len = data_wr_len; end
            default: ;
        endcase
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            grant_id      <= ID_NONE;
            busy          <= 1'b0;
            rd_burst_req  <= 1'b0;
            wr_burst_req  <= 1'b0;
            rd_burst_addr <= '0;
            wr_burst_addr <= '0;
            rd_burst_len  <= '0;
            wr_burst_len  <= '0;
            isa_rd_done   <= 1'b0;
            data_rd_done  <= 1'b0;
            data_wr_done  <= 1'b0;
`ifdef DDR_ARB_ROUND_ROBIN_EN
            rr_ptr        <= 2'd0;
`endif
        end else begin
            isa_rd_done  <= 1'b0;
            data_rd_done <= 1'b0;
            data_wr_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (init_calib_complete && sel_id != ID_NONE) begin
                        grant_id <= sel_id;
                        busy     <= 1'b1;
                        if (sel_id == ID_DWR) begin
                            wr_burst_addr <= sel_addr;
                            wr_burst_len  <= sel_len;
                        end else begin
                            rd_burst_addr <= sel_addr;
                            rd_burst_len  <= sel_len;
                        end
                        // Zero-length bursts complete without touching the controller.
                        if (sel_len == '0) begin
                            state        <= S_DONE;
                            isa_rd_done  <= (sel_id == ID_ISA);
                            data_rd_done <= (sel_id == ID_DRD);
                            data_wr_done <= (sel_id == ID_DWR);
                        end else begin
                            state <= (sel_id == ID_DWR) ? S_WR : S_RD;
                        end
`ifdef DDR_ARB_ROUND_ROBIN_EN
                        rr_ptr <= (sel_id == ID_DWR) ? 2'd0 : sel_id;
`endif
                    end
                end
                S_RD: begin
                    if (!rd_burst_req) begin
                        rd_burst_req <= 1'b1;
                    end else if (rd_burst_finish) begin
                        rd_burst_req <= 1'b0;
                        state        <= S_DONE;
                        isa_rd_done  <= (grant_id == ID_ISA);
                        data_rd_done <= (grant_id == ID_DRD);
                    end
                end
                S_WR: begin
                    if (!wr_burst_req) begin
                        wr_burst_req <= 1'b1;
                    end else if (wr_burst_finish) begin
                        wr_burst_req <= 1'b0;
                        state        <= S_DONE;
                        data_wr_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    grant_id <= ID_NONE;
                    busy     <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ddr_burst_arbiter.md
DDR_BURST_ARBITER -- requirements
Module: ddr_burst_arbiter

Interface
REQ-001 SHALL have parameter DDR_ADDR_WIDTH, default 28, DDR burst address width.
REQ-002 SHALL have parameter BURST_LEN_WIDTH, default 10, burst length width.
REQ-003 SHALL have port mem_clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port init_calib_complete  input  1  DDR ready; no grant while low.
REQ-006 SHALL have ports isa_rd_req / data_rd_req / data_wr_req  input  1 each  level request per requester.
REQ-007 SHALL have ports isa_rd_addr / data_rd_addr / data_wr_addr  input  DDR_ADDR_WIDTH each  burst start address.
REQ-008 SHALL have ports isa_rd_len / data_rd_len / data_wr_len  input  BURST_LEN_WIDTH each  burst length in beats.
REQ-009 SHALL have ports isa_rd_done / data_rd_done / data_wr_done  output  1 each  one-cycle completion pulse.
REQ-010 SHALL have ports rd_burst_req, wr_burst_req  output  1 each  burst request to the DDR controller.
REQ-011 SHALL have ports rd_burst_addr, wr_burst_addr  output  DDR_ADDR_WIDTH each  latched address.
REQ-012 SHALL have ports rd_burst_len, wr_burst_len  output  BURST_LEN_WIDTH each  latched length.
REQ-013 SHALL have ports rd_burst_finish, wr_burst_finish  input  1 each  completion from the DDR controller.
REQ-014 SHALL have port busy  output  1  high when state is not IDLE.
REQ-015 SHALL have port grant_id  output  2  owner: 0 none, 1 isa_rd, 2 data_rd, 3 data_wr.

Function
REQ-016 SHALL implement states IDLE, RD, WR, DONE; all outputs registered.
REQ-017 In IDLE with init_calib_complete=1 and any req high: SHALL select one requester, latch its addr/len, set grant_id, and go to RD (reads) or WR (write).
REQ-018 The burst request SHALL rise on the cycle after selection and stay high, with addr/len stable, until the matching finish is sampled high.
REQ-019 On the matching finish, the burst request SHALL drop and the state SHALL go to DONE; in DONE the owner's done pulses high for exactly one cycle, then the state returns to IDLE and grant_id returns to 0.
REQ-020 SHALL perform no arbitration in DONE; this gives a one-cycle minimum gap between bursts.
REQ-021 A selected request with len==0 SHALL go directly to DONE, pulse done, and never assert a burst request.
REQ-022 SHALL ignore rd_burst_finish in WR, wr_burst_finish in RD, and both finishes in IDLE or DONE.
REQ-023 If init_calib_complete falls during RD or WR, the burst in flight SHALL complete normally; new grants are blocked.
REQ-024 A req dropped before done SHALL NOT abort the burst in flight; requesters hold req, addr and len stable until done.
REQ-025 rd_burst_req and wr_burst_req SHALL never be high together.

Reset
REQ-026 rst_n low SHALL force IDLE asynchronously, clear all req, done and busy outputs, set addr/len outputs to 0 and grant_id to 0, and reset the round-robin pointer to isa_rd.
REQ-027 Reset mid-burst SHALL abandon the burst without a done pulse.

Configuration
REQ-028 With macro DDR_ARB_ROUND_ROBIN_EN defined: selection SHALL be round-robin in the order isa_rd -> data_rd -> data_wr, searching from the requester after the last granted one.
REQ-029 Without DDR_ARB_ROUND_ROBIN_EN: selection SHALL be fixed priority, data_wr > data_rd > isa_rd.

Verification
REQ-030 Single read: isa_rd_req with addr 0x0000100, len 72 -> next cycle rd_burst_req=1, rd_burst_addr=0x0000100, rd_burst_len=72 held until rd_burst_finish; isa_rd_done pulses one cycle after finish.
REQ-031 Simultaneous requests, fixed priority: all three req high -> grant order data_wr, data_rd, isa_rd, with one gap cycle between bursts.
REQ-032 Simultaneous requests, DDR_ARB_ROUND_ROBIN_EN: all three req held high for 6 bursts -> grant_id sequence 1,2,3,1,2,3.
REQ-033 Calibration gating: init_calib_complete=0 with data_rd_req high -> no burst request; calibration rises -> rd_burst_req asserts 2 cycles later.
REQ-034 Zero length and stray finish: data_wr_len=0 -> data_wr_done pulses with no wr_burst_req; wr_burst_finish during RD -> ignored; rst_n low mid-RD -> rd_burst_req=0 immediately, no done pulse.
